// File: rtl/parametric_fifo.sv
// Purpose : single-clock synchronous FIFO; DEPTH = 1<<POINTER words of WIDTH bits, registered count with level flags.
// Latency : FWFT=0 -> data_out loads on the accepting read edge; FWFT=1 -> a word appears one cycle after its write edge.
// Backpr. : writes are refused while write_full and reads while read_empty; each refusal sets a sticky overflow/underflow flag.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   write_en, data_in - write request and data
//   read_en, data_out - read request and data
//   write_full, read_empty, almost_full, almost_empty - level flags decoded from count
//   count             - stored words, 0..DEPTH
//   overflow, underflow - sticky refusal flags, cleared only by reset
module parametric_fifo #(
  parameter int WIDTH      = 8,
  parameter int POINTER    = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               read_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               write_full,
  output logic               read_empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [POINTER:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int              DEPTH     = 1 << POINTER;
  localparam logic [POINTER:0] LP_DEPTH  = (POINTER+1)'(DEPTH);
  localparam logic [POINTER:0] LP_AFULL  = (POINTER+1)'(AFULL_LVL);
  localparam logic [POINTER:0] LP_AEMPTY = (POINTER+1)'(AEMPTY_LVL);
  localparam logic [POINTER:0] LP_ONE    = (POINTER+1)'(1);
  localparam logic [POINTER:0] LP_ZERO   = '0;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [POINTER:0]  r_wr_ptr;
  logic [POINTER:0]  r_rd_ptr;
  logic [POINTER:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags come only from the registered count, so they settle one cycle
  // after the accepting edge and never depend on this cycle's requests.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == LP_ZERO);

  // Acceptance is judged against the current occupancy: a collision when
  // full lets the read through and refuses the write, and vice versa when
  // empty. A freshly written word is never readable in the same cycle.
  assign w_wr_acc = write_en && !w_full;
  assign w_rd_acc = read_en && !w_empty;

  assign write_full   = w_full;
  assign read_empty   = w_empty;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Pointers carry one extra wrap bit and simply roll over modulo 2*DEPTH;
  // occupancy is tracked by r_count rather than by pointer comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + LP_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + LP_ONE;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
      if (write_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (read_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; stale words are unreachable
  // because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr[POINTER-1:0]] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is shown continuously; only meaningful when not empty.
      assign data_out = r_mem[r_rd_ptr[POINTER-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr[POINTER-1:0]];
        end
      end

      assign data_out = r_dout;
    end
  endgenerate

endmodule
